// File: rtl/rob_module_pkg.sv
// rtl/rob_module_pkg.sv - shared sizes, entry layout and pointer helper for the reorder buffer
package rob_module_pkg;

    localparam int ROB_SIZE     = 8;
    localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
    localparam int DATA_W       = 64;
    localparam int GPR_IDX_W    = 5;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                 valid;
        logic                 ready;
        logic                 mispredict;
        logic                 set_nzcv;
        logic [GPR_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    value;
        nzcv_t                nzcv;
    } rob_entry_t;

    // ROB_SIZE is a power of two, so the natural index overflow is the wrap
    function automatic logic [ROB_IDX_SIZE-1:0] rob_inc(input logic [ROB_IDX_SIZE-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/occupancy bookkeeping for the reorder buffer
module rob_ptr_ctrl
    import rob_module_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc,
    input  logic                    commit,
    input  logic                    flush,
    output logic [ROB_IDX_SIZE-1:0] head,
    output logic [ROB_IDX_SIZE-1:0] tail,
    output logic                    full
);

    logic [ROB_IDX_SIZE:0] count;

    // Pointers advance independently; flush returns the buffer to its empty reset shape
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) begin
                tail <= rob_inc(tail);
            end
            if (commit) begin
                head <= rob_inc(head);
            end
            if (alloc && !commit) begin
                count <= count + 1'b1;
            end else if (commit && !alloc) begin
                count <= count - 1'b1;
            end
        end
    end

    // Full is decoded from the registered count so decode sees a glitch-free stall
    always_comb begin
        full = (count == (ROB_IDX_SIZE + 1)'(ROB_SIZE));
    end

endmodule

// File: rtl/rob_module.sv
// rtl/rob_module.sv - reorder buffer: allocate in order, capture results out of order, retire in order
module rob_module
    import rob_module_pkg::*;
(
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_reg_done,
    input  logic [GPR_IDX_W-1:0]    in_reg_dst,
    input  logic                    in_reg_set_nzcv,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
    input  logic [DATA_W-1:0]       in_fu_value,
    input  nzcv_t                   in_fu_nzcv,
    input  logic                    in_fu_mispredict,
    output logic [ROB_IDX_SIZE-1:0] out_next_rob_index,
    output logic                    out_full,
    output logic                    out_commit_done,
    output logic [ROB_IDX_SIZE-1:0] out_commit_rob_index,
    output logic [GPR_IDX_W-1:0]    out_commit_reg_index,
    output logic [DATA_W-1:0]       out_commit_value,
    output logic                    out_commit_set_nzcv,
    output nzcv_t                   out_commit_nzcv,
    output logic                    out_flush
);

    rob_entry_t                entries [ROB_SIZE];
    rob_entry_t                head_entry;
    logic [ROB_IDX_SIZE-1:0]   head;
    logic [ROB_IDX_SIZE-1:0]   tail;
    logic                      full;
    logic                      commit_fire;
    logic                      flush_fire;
    logic                      alloc_fire;
    logic                      wb_fire;

    rob_ptr_ctrl u_ptr (
        .clk    (in_clk),
        .rst_n  (in_rst_n),
        .alloc  (alloc_fire),
        .commit (commit_fire),
        .flush  (flush_fire),
        .head   (head),
        .tail   (tail),
        .full   (full)
    );

    // Event decode; a full buffer refuses allocation even while it is retiring, and a flush swallows
    // any allocate on the same edge
    always_comb begin
        head_entry  = entries[head];
        commit_fire = head_entry.valid && head_entry.ready;
        flush_fire  = commit_fire && head_entry.mispredict;
        alloc_fire  = in_reg_done && !full && !flush_fire;
        wb_fire     = in_fu_done && entries[in_fu_rob_index].valid;
    end

    // Entry array: writeback, retirement and allocation, with flush invalidating everything
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (flush_fire) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (wb_fire) begin
                entries[in_fu_rob_index].ready      <= 1'b1;
                entries[in_fu_rob_index].value      <= in_fu_value;
                entries[in_fu_rob_index].nzcv       <= in_fu_nzcv;
                entries[in_fu_rob_index].mispredict <= in_fu_mispredict;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                entries[head].ready <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail].valid      <= 1'b1;
                entries[tail].ready      <= 1'b0;
                entries[tail].mispredict <= 1'b0;
                entries[tail].dst        <= in_reg_dst;
                entries[tail].set_nzcv   <= in_reg_set_nzcv;
            end
        end
    end

    // Registered commit port; payload holds between strobes, strobe and flush are single-cycle
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_commit_done      <= 1'b0;
            out_commit_rob_index <= '0;
            out_commit_reg_index <= '0;
            out_commit_value     <= '0;
            out_commit_set_nzcv  <= 1'b0;
            out_commit_nzcv      <= '0;
            out_flush            <= 1'b0;
        end else begin
            out_commit_done <= commit_fire;
            out_flush       <= flush_fire;
            if (commit_fire) begin
                out_commit_rob_index <= head;
                out_commit_reg_index <= head_entry.dst;
                out_commit_value     <= head_entry.value;
                out_commit_set_nzcv  <= head_entry.set_nzcv;
                out_commit_nzcv      <= head_entry.nzcv;
            end
        end
    end

    // Rename tag and stall straight from pointer state
    always_comb begin
        out_next_rob_index = tail;
        out_full           = full;
    end

endmodule

// File: tb/tb_rob_module.sv
// tb/tb_rob_module.sv - randomized and directed bench for rob_module against an in-order queue model
module tb_rob_module;
    import rob_module_pkg::*;

    logic                    clk = 1'b0;
    logic                    in_rst_n;
    logic                    in_reg_done;
    logic [GPR_IDX_W-1:0]    in_reg_dst;
    logic                    in_reg_set_nzcv;
    logic                    in_fu_done;
    logic [ROB_IDX_SIZE-1:0] in_fu_rob_index;
    logic [DATA_W-1:0]       in_fu_value;
    nzcv_t                   in_fu_nzcv;
    logic                    in_fu_mispredict;
    logic [ROB_IDX_SIZE-1:0] out_next_rob_index;
    logic                    out_full;
    logic                    out_commit_done;
    logic [ROB_IDX_SIZE-1:0] out_commit_rob_index;
    logic [GPR_IDX_W-1:0]    out_commit_reg_index;
    logic [DATA_W-1:0]       out_commit_value;
    logic                    out_commit_set_nzcv;
    nzcv_t                   out_commit_nzcv;
    logic                    out_flush;

    always #5 clk = ~clk;

    rob_module dut (
        .in_clk               (clk),
        .in_rst_n             (in_rst_n),
        .in_reg_done          (in_reg_done),
        .in_reg_dst           (in_reg_dst),
        .in_reg_set_nzcv      (in_reg_set_nzcv),
        .in_fu_done           (in_fu_done),
        .in_fu_rob_index      (in_fu_rob_index),
        .in_fu_value          (in_fu_value),
        .in_fu_nzcv           (in_fu_nzcv),
        .in_fu_mispredict     (in_fu_mispredict),
        .out_next_rob_index   (out_next_rob_index),
        .out_full             (out_full),
        .out_commit_done      (out_commit_done),
        .out_commit_rob_index (out_commit_rob_index),
        .out_commit_reg_index (out_commit_reg_index),
        .out_commit_value     (out_commit_value),
        .out_commit_set_nzcv  (out_commit_set_nzcv),
        .out_commit_nzcv      (out_commit_nzcv),
        .out_flush            (out_flush)
    );

    typedef struct {
        int          idx;
        int          dst;
        bit          snz;
        bit          rdy;
        logic [63:0] val;
        logic [3:0]  nzcv;
        bit          mis;
    } ment_t;

    ment_t       q[$];
    int          m_tail = 0;
    int          seen_idx[$];
    logic [63:0] seen_val[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rd, input int dst, input bit snz, input bit fd, input int fidx,
                        input logic [63:0] val, input logic [3:0] nz, input bit mis);
        bit    e_commit;
        bit    e_flush;
        ment_t e;
        ment_t n;
        in_reg_done      = rd;
        in_reg_dst       = dst[4:0];
        in_reg_set_nzcv  = snz;
        in_fu_done       = fd;
        in_fu_rob_index  = fidx[2:0];
        in_fu_value      = val;
        in_fu_nzcv       = nz;
        in_fu_mispredict = mis;
        e_commit = (q.size() > 0) && q[0].rdy;
        e = '{idx: 0, dst: 0, snz: 0, rdy: 0, val: 0, nzcv: 0, mis: 0};
        if (e_commit) e = q[0];
        e_flush = e_commit && e.mis;
        if (e_flush) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (fd) begin
                foreach (q[i]) begin
                    if (q[i].idx == fidx) begin
                        q[i].rdy  = 1;
                        q[i].val  = val;
                        q[i].nzcv = nz;
                        q[i].mis  = mis;
                    end
                end
            end
            if (rd && q.size() < ROB_SIZE) begin
                n = '{idx: m_tail, dst: dst, snz: snz, rdy: 0, val: 0, nzcv: 0, mis: 0};
                q.push_back(n);
                m_tail = (m_tail + 1) % ROB_SIZE;
            end
            if (e_commit) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("commit_done", 64'(out_commit_done), 64'(e_commit));
        if (e_commit) begin
            chk("commit_idx", 64'(out_commit_rob_index), 64'(e.idx));
            chk("commit_reg", 64'(out_commit_reg_index), 64'(e.dst));
            chk("commit_val", out_commit_value, e.val);
            chk("commit_snz", 64'(out_commit_set_nzcv), 64'(e.snz));
            chk("commit_nzcv", 64'(out_commit_nzcv), 64'(e.nzcv));
        end
        chk("flush", 64'(out_flush), 64'(e_flush));
        chk("next_idx", 64'(out_next_rob_index), 64'(m_tail));
        chk("full", 64'(out_full), 64'(q.size() == ROB_SIZE));
        if (out_commit_done) begin
            seen_idx.push_back(int'(out_commit_rob_index));
            seen_val.push_back(out_commit_value);
        end
        in_reg_done      = 1'b0;
        in_fu_done       = 1'b0;
        in_fu_mispredict = 1'b0;
    endtask

    task automatic alloc(input int dst);
        step(1, dst, dst[0], 0, 0, 64'd0, 4'd0, 0);
    endtask

    task automatic wb(input int idx, input logic [63:0] val, input bit mis);
        step(0, 0, 0, 1, idx, val, val[3:0], mis);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 64'd0, 4'd0, 0);
    endtask

    task automatic reset_dut();
        in_rst_n = 1'b0;
        #3;
        in_rst_n = 1'b1;
        q.delete();
        m_tail = 0;
        seen_idx.delete();
        seen_val.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 64'(out_commit_done), 64'd0);
        chk({tag, "_idx"}, 64'(out_commit_rob_index), 64'd0);
        chk({tag, "_reg"}, 64'(out_commit_reg_index), 64'd0);
        chk({tag, "_val"}, out_commit_value, 64'd0);
        chk({tag, "_snz"}, 64'(out_commit_set_nzcv), 64'd0);
        chk({tag, "_nzcv"}, 64'(out_commit_nzcv), 64'd0);
        chk({tag, "_flush"}, 64'(out_flush), 64'd0);
        chk({tag, "_next"}, 64'(out_next_rob_index), 64'd0);
        chk({tag, "_full"}, 64'(out_full), 64'd0);
    endtask

    initial begin
        in_rst_n = 1'b0;
        in_reg_done = 1'b0; in_reg_dst = '0; in_reg_set_nzcv = 1'b0;
        in_fu_done = 1'b0; in_fu_rob_index = '0; in_fu_value = '0; in_fu_nzcv = '0;
        in_fu_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        in_rst_n = 1'b1;

        // in-order retirement of out-of-order results
        alloc(1); alloc(2); alloc(3);
        wb(2, 64'd30, 0); wb(0, 64'd10, 0); wb(1, 64'd20, 0);
        idle(3);
        chk("t1_count", 64'(seen_idx.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen_idx.size(); i++) begin
            chk("t1_idx", 64'(seen_idx[i]), 64'(i));
            chk("t1_val", seen_val[i], 64'(10 * (i + 1)));
        end

        // fill to full, dropped ninth request, drain one
        reset_dut();
        for (int i = 0; i < 8; i++) alloc(i + 4);
        chk("t2_full", 64'(out_full), 64'd1);
        chk("t2_next", 64'(out_next_rob_index), 64'd0);
        alloc(20);
        chk("t2_tail_hold", 64'(out_next_rob_index), 64'd0);
        wb(0, 64'h55, 0);
        idle(1);
        chk("t2_not_full", 64'(out_full), 64'd0);

        // pointer wrap
        reset_dut();
        for (int i = 0; i < 6; i++) alloc(i);
        for (int i = 0; i < 6; i++) wb(i, 64'(100 + i), 0);
        idle(2);
        seen_idx.delete();
        for (int i = 0; i < 4; i++) alloc(10 + i);
        wb(1, 64'd71, 0); wb(0, 64'd70, 0); wb(7, 64'd77, 0); wb(6, 64'd76, 0);
        idle(5);
        chk("t3_count", 64'(seen_idx.size()), 64'd4);
        if (seen_idx.size() == 4) begin
            chk("t3_i0", 64'(seen_idx[0]), 64'd6);
            chk("t3_i1", 64'(seen_idx[1]), 64'd7);
            chk("t3_i2", 64'(seen_idx[2]), 64'd0);
            chk("t3_i3", 64'(seen_idx[3]), 64'd1);
        end

        // mispredict flush
        reset_dut();
        for (int i = 0; i < 4; i++) alloc(i + 1);
        wb(1, 64'hB1, 1); wb(0, 64'hB0, 0); wb(2, 64'hB2, 0); wb(3, 64'hB3, 0);
        idle(4);
        chk("t4_commits", 64'(seen_idx.size()), 64'd2);
        chk("t4_next", 64'(out_next_rob_index), 64'd0);

        // steady occupancy with simultaneous allocate/commit, stray writeback
        reset_dut();
        for (int i = 0; i < 5; i++) alloc(i);
        wb(0, 64'hC0, 0);
        alloc(9);
        chk("t5_next", 64'(out_next_rob_index), 64'd6);
        wb(6, 64'hC6, 0);
        idle(3);

        // asynchronous reset mid commit stream
        reset_dut();
        alloc(4); alloc(5); alloc(6);
        wb(0, 64'hD0, 0); wb(1, 64'hD1, 0); wb(2, 64'hD2, 0);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2;
        in_rst_n = 1'b1;
        q.delete();
        m_tail = 0;
        seen_idx.delete();
        idle(3);
        chk("t6_no_commit", 64'(seen_idx.size()), 64'd0);

        // randomized traffic
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            bit          rd;
            bit          fd;
            int          fidx;
            logic [63:0] v;
            rd = ($urandom_range(0, 99) < 55);
            fd = ($urandom_range(0, 99) < 60);
            if (q.size() > 0 && $urandom_range(0, 9) < 8) fidx = q[$urandom_range(0, q.size() - 1)].idx;
            else fidx = $urandom_range(0, ROB_SIZE - 1);
            v = {$urandom, $urandom};
            step(rd, $urandom_range(0, 31), $urandom_range(0, 1), fd, fidx, v, v[7:4],
                 ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
